minibus_arbiter: RTL and testbench

MINIBUS_ARBITER -- requirements
Module: minibus_arbiter

---
 rtl/minibus_arbiter.sv | 131 +++++++++++++
 tb/tb_minibus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minibus_arbiter.sv
// minibus_arbiter: round-robin arbiter granting one of MASTER_COUNT masters access to a single
// minibus decoder port. A grant is taken in IDLE and held for one transaction in BUSY. The
// transaction ends on slave completion, on timeout, or when the owner withdraws its request.
//
// Ports:
//   clk, rst            single clock; synchronous active-high reset
//   m_valid, m_wen      per-master request pending / write select
//   m_addr, m_wdata     per-master request address and write data
//   m_ready, m_err      one-cycle completion / timeout pulses to the granted master
//   m_rdata             shared read data, valid only alongside m_ready (0 otherwise)
//   bus_valid, bus_wen, bus_addr, bus_wdata   granted request toward the decoder
//   bus_ready, bus_rdata                      slave completion and read data
//   grant_id            index of the current owner; 0 when idle
module minibus_arbiter #(
   parameter int unsigned MASTER_COUNT = 4,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [MASTER_COUNT-1:0]              m_valid,
   input  logic [MASTER_COUNT-1:0]              m_wen,
   input  logic [MASTER_COUNT-1:0][ADDR_W-1:0]  m_addr,
   input  logic [MASTER_COUNT-1:0][DATA_W-1:0]  m_wdata,
   output logic [MASTER_COUNT-1:0]              m_ready,
   output logic [MASTER_COUNT-1:0]              m_err,
   output logic [DATA_W-1:0]                    m_rdata,
   output logic                                 bus_valid,
   output logic                                 bus_wen,
   output logic [ADDR_W-1:0]                    bus_addr,
   output logic [DATA_W-1:0]                    bus_wdata,
   input  logic                                 bus_ready,
   input  logic [DATA_W-1:0]                    bus_rdata,
   output logic [$clog2(MASTER_COUNT)-1:0]      grant_id
);

   localparam int unsigned GrantW = $clog2(MASTER_COUNT);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e              state_q, state_d;
   logic [GrantW-1:0]   grant_q, grant_d;
   logic [GrantW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]         wait_q, wait_d;

   logic [GrantW-1:0]   next_ptr;
   logic                found;
   int unsigned         idx;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      wait_d    = wait_q;
      found     = 1'b0;
      idx       = 0;
      m_ready   = '0;
      m_err     = '0;
      m_rdata   = '0;
      bus_valid = 1'b0;
      bus_wen   = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      grant_id  = '0;
      // Pointer after the current owner, so it gets lowest priority next round.
      next_ptr  = (grant_q == GrantW'(MASTER_COUNT - 1)) ? '0 : grant_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            // First requester at or above rr_ptr, wrapping back to master 0.
            for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
               idx = 32'(rr_ptr_q) + i;
               if (idx >= MASTER_COUNT) begin
                  idx = idx - MASTER_COUNT;
               end
               if (!found && m_valid[GrantW'(idx)]) begin
                  found   = 1'b1;
                  grant_d = GrantW'(idx);
               end
            end
            if (found) begin
               state_d = StBusy;
               wait_d  = '0;
            end
         end
         StBusy: begin
            grant_id = grant_q;
            if (!m_valid[grant_q]) begin
               // Owner withdrew: drop the request silently.
               state_d  = StIdle;
               rr_ptr_d = next_ptr;
            end else begin
               bus_valid = 1'b1;
               bus_wen   = m_wen[grant_q];
               bus_addr  = m_addr[grant_q];
               bus_wdata = m_wdata[grant_q];
               if (bus_ready) begin
                  // Completion wins over a coincident timeout.
                  m_ready[grant_q] = 1'b1;
                  m_rdata          = bus_rdata;
                  state_d          = StIdle;
                  rr_ptr_d         = next_ptr;
               end else if (wait_q == 16'(TIMEOUT)) begin
                  m_err[grant_q] = 1'b1;
                  state_d        = StIdle;
                  rr_ptr_d       = next_ptr;
               end else begin
                  wait_d = wait_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         wait_q   <= wait_d;
      end
   end

endmodule

// File: tb/tb_minibus_arbiter.sv
// tb_minibus_arbiter: directed stimulus for minibus_arbiter with a transaction-level model
// compared on every falling edge, plus hand-computed literal checks at key cycles.
module tb_minibus_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam int GW = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N-1:0]            m_valid, m_wen;
   logic [N-1:0][AW-1:0]    m_addr;
   logic [N-1:0][DW-1:0]    m_wdata;
   logic [N-1:0]            m_ready, m_err;
   logic [DW-1:0]           m_rdata;
   logic                    bus_valid, bus_wen;
   logic [AW-1:0]           bus_addr;
   logic [DW-1:0]           bus_wdata;
   logic                    bus_ready;
   logic [DW-1:0]           bus_rdata;
   logic [GW-1:0]           grant_id;

   minibus_arbiter #(
      .MASTER_COUNT(N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT     (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_valid  (m_valid),
      .m_wen    (m_wen),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_ready  (m_ready),
      .m_err    (m_err),
      .m_rdata  (m_rdata),
      .bus_valid(bus_valid),
      .bus_wen  (bus_wen),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_ready(bus_ready),
      .bus_rdata(bus_rdata),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // Transaction-level model: who owns the bus, for how many cycles, and whose turn is next.
   bit           mdl_busy   = 1'b0;
   int           mdl_owner  = 0;
   int           mdl_ptr    = 0;
   int           mdl_cycles = 0;
   bit           mdl_done;
   logic [N-1:0] e_ready, e_err;
   logic [DW-1:0] e_rdata, e_wdata;
   logic [AW-1:0] e_addr;
   logic         e_bv, e_wen;
   int           e_gid;

   always @(negedge clk) begin
      e_ready  = '0;
      e_err    = '0;
      e_rdata  = '0;
      e_wdata  = '0;
      e_addr   = '0;
      e_bv     = 1'b0;
      e_wen    = 1'b0;
      e_gid    = 0;
      mdl_done = 1'b0;
      if (mdl_busy) begin
         e_gid = mdl_owner;
         if (m_valid[GW'(mdl_owner)]) begin
            e_bv    = 1'b1;
            e_wen   = m_wen[GW'(mdl_owner)];
            e_addr  = m_addr[GW'(mdl_owner)];
            e_wdata = m_wdata[GW'(mdl_owner)];
            if (bus_ready) begin
               e_ready[GW'(mdl_owner)] = 1'b1;
               e_rdata  = bus_rdata;
               mdl_done = 1'b1;
            end else if (mdl_cycles == TO + 1) begin
               e_err[GW'(mdl_owner)] = 1'b1;
               mdl_done = 1'b1;
            end
         end else begin
            mdl_done = 1'b1;
         end
      end
      check("m_ready",   32'(m_ready),   32'(e_ready));
      check("m_err",     32'(m_err),     32'(e_err));
      check("m_rdata",   32'(m_rdata),   32'(e_rdata));
      check("bus_valid", 32'(bus_valid), 32'(e_bv));
      check("bus_wen",   32'(bus_wen),   32'(e_wen));
      check("bus_addr",  32'(bus_addr),  32'(e_addr));
      check("bus_wdata", 32'(bus_wdata), 32'(e_wdata));
      check("grant_id",  32'(grant_id),  32'(e_gid));
      if (rst) begin
         mdl_busy   = 1'b0;
         mdl_owner  = 0;
         mdl_ptr    = 0;
         mdl_cycles = 0;
      end else if (mdl_busy) begin
         if (mdl_done) begin
            mdl_busy = 1'b0;
            mdl_ptr  = (mdl_owner + 1) % N;
         end else begin
            mdl_cycles++;
         end
      end else if (m_valid != '0) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (m_valid[GW'((mdl_ptr + k) % N)]) mdl_owner = (mdl_ptr + k) % N;
         end
         mdl_busy   = 1'b1;
         mdl_cycles = 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int           ord [5] = '{0, 1, 2, 3, 0};
   logic [N-1:0] onehot;

   initial begin
      rst       = 1'b1;
      m_valid   = '0;
      m_wen     = '0;
      m_addr[0] = 32'h0000_0100;
      m_addr[1] = 32'h0000_2004;
      m_addr[2] = 32'h0000_3008;
      m_addr[3] = 32'h0000_400C;
      m_wdata[0] = 32'h1111_0000;
      m_wdata[1] = 32'h2222_0001;
      m_wdata[2] = 32'h3333_0002;
      m_wdata[3] = 32'h4444_0003;
      bus_ready = 1'b0;
      bus_rdata = '0;

      // Reset state
      tick();
      tick();
      #1;
      check("rst bus_valid", 32'(bus_valid), 32'd0);
      check("rst grant_id",  32'(grant_id),  32'd0);
      check("rst m_ready",   32'(m_ready),   32'd0);
      check("rst m_rdata",   32'(m_rdata),   32'd0);

      // Single master read, completed in the first BUSY cycle
      tick();
      rst       = 1'b0;
      m_valid   = 4'b0001;
      bus_ready = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      #1;
      check("single idle m_ready", 32'(m_ready), 32'd0);
      tick();
      #1;
      check("single m_ready",  32'(m_ready),  32'h1);
      check("single m_rdata",  32'(m_rdata),  32'hDEAD_BEEF);
      check("single bus_addr", 32'(bus_addr), 32'h100);
      tick();
      m_valid = '0;
      rst     = 1'b1;

      // Round robin with all masters requesting
      tick();
      rst       = 1'b0;
      m_valid   = 4'b1111;
      bus_rdata = 32'hA5A5_0000;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("rr bus_valid", 32'(bus_valid), 32'(i % 2));
         if (i % 2 == 1) begin
            onehot = '0;
            onehot[GW'(ord[i / 2])] = 1'b1;
            check("rr grant_id", 32'(grant_id), 32'(ord[i / 2]));
            check("rr m_ready",  32'(m_ready),  32'(onehot));
         end
         tick();
      end

      // Timeout on master 1, error on the fifth BUSY cycle
      m_valid   = 4'b0010;
      m_wen     = 4'b0010;
      bus_ready = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         tick();
         if (j == 6) begin
            m_valid = 4'b0100;
            m_wen   = '0;
         end
         #1;
         check("to bus_valid", 32'(bus_valid), (j <= 5) ? 32'd1 : 32'd0);
         check("to m_err",     32'(m_err),     (j == 5) ? 32'h2 : 32'h0);
      end

      // Completion on the timeout cycle beats the error (master 2)
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 5) begin
            bus_ready = 1'b1;
            bus_rdata = 32'h1234_5678;
         end
         #1;
         check("tr m_ready", 32'(m_ready), (k == 5) ? 32'h4 : 32'h0);
         check("tr m_err",   32'(m_err),   32'h0);
      end
      check("tr m_rdata", 32'(m_rdata), 32'h1234_5678);

      // Abort: master 2 regranted (rr_ptr=3) and then withdraws after two BUSY cycles
      tick();
      bus_ready = 1'b0;
      tick();
      #1;
      check("ab grant_id", 32'(grant_id), 32'd2);
      tick();
      #1;
      check("ab bus_valid b2", 32'(bus_valid), 32'd1);
      tick();
      m_valid = 4'b1001;
      m_wen   = 4'b1000;
      #1;
      check("ab bus_valid drop", 32'(bus_valid), 32'd0);
      check("ab m_ready", 32'(m_ready), 32'd0);
      check("ab m_err",   32'(m_err),   32'd0);
      tick();
      tick();
      #1;
      check("ab next grant",  32'(grant_id),  32'd3);
      check("ab bus_wen",     32'(bus_wen),   32'd1);
      check("ab bus_wdata",   32'(bus_wdata), 32'h4444_0003);

      // Reset during a pending write from master 3
      tick();
      rst = 1'b1;
      tick();
      m_valid = 4'b1010;
      m_wen   = '0;
      #1;
      check("mr bus_valid", 32'(bus_valid), 32'd0);
      check("mr grant_id",  32'(grant_id),  32'd0);
      check("mr m_ready",   32'(m_ready),   32'd0);
      check("mr bus_addr",  32'(bus_addr),  32'd0);
      tick();
      rst = 1'b0;
      tick();
      bus_ready = 1'b1;
      bus_rdata = 32'h0BAD_F00D;
      #1;
      check("mr regrant", 32'(grant_id), 32'd1);
      check("mr m_ready", 32'(m_ready),  32'h2);
      tick();
      m_valid   = '0;
      bus_ready = 1'b0;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
